// File: rtl/rf_pkg.sv
// Shared definitions for the integer register file and the opcode-steered
// register-file mux that feeds it.
package rf_pkg;

    localparam int RF_NUM_REGS = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;

    typedef enum logic {
        RF_ST_CLEAR = 1'b0,
        RF_ST_READY = 1'b1
    } rf_state_t;

    // RV32I major opcodes, shared with the register-file mux
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: owns the register-file write port after reset or on a
// clear request and walks entries 1..NUM_REGS-1 writing zero.
//
// state       | meaning
// RF_ST_CLEAR | zeroing entry cnt this edge, array unavailable
// RF_ST_READY | normal operation, array owned by the core
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int ADDR_W   = RF_ADDR_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] CNT_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] CNT_LAST  = ADDR_W'(NUM_REGS - 1);

    rf_state_t         state;
    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RF_ST_CLEAR;
            cnt   <= CNT_FIRST;
            busy  <= 1'b1;
        end else begin
            case (state)
                RF_ST_CLEAR: begin
                    // cnt parks at the last entry rather than wrapping to x0
                    if (cnt == CNT_LAST) begin
                        state <= RF_ST_READY;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_FIRST;
                    end
                end
                RF_ST_READY: begin
                    if (clr_req) begin
                        state <= RF_ST_CLEAR;
                        cnt   <= CNT_FIRST;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    state <= RF_ST_CLEAR;
                    cnt   <= CNT_FIRST;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    assign clr_we   = busy;
    assign clr_addr = cnt;

endmodule

// File: rtl/register_file_core.sv
// RV32I integer register file: two combinational read ports, one write port,
// hardwired x0, optional write-to-read bypass and a sequenced clear engine.
module register_file_core
    import rf_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int DATA_W   = RF_DATA_W,
    parameter int BYPASS   = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_CLR,
    input  logic              i_WE,
    input  logic [ADDR_W-1:0] i_RD,
    input  logic [ADDR_W-1:0] i_RS1,
    input  logic [ADDR_W-1:0] i_RS2,
    input  logic [DATA_W-1:0] i_REG_IN,
    output logic [DATA_W-1:0] o_REG_OUT1,
    output logic [DATA_W-1:0] o_REG_OUT2,
    output logic              o_BUSY
);

    logic [DATA_W-1:0] mem [NUM_REGS];
    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              rd_nonzero;
    logic              user_we;
    logic              byp_en;

    rf_clear_seq #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_clear_seq (
        .CLK      (CLK),
        .RST      (RST),
        .clr_req  (i_CLR),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign rd_nonzero = (i_RD != '0);
    // A clear request in the same cycle takes the array, so the write is lost
    assign user_we    = i_WE && rd_nonzero && !busy && !i_CLR;
    assign byp_en     = (BYPASS != 0) && i_WE && rd_nonzero && !busy;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (clr_we) begin
                mem[clr_addr] <= '0;
            end else if (user_we) begin
                mem[i_RD] <= i_REG_IN;
            end
        end
    end

    always_comb begin
        o_REG_OUT1 = '0;
        if (!busy && (i_RS1 != '0)) begin
            o_REG_OUT1 = (byp_en && (i_RD == i_RS1)) ? i_REG_IN : mem[i_RS1];
        end
    end

    always_comb begin
        o_REG_OUT2 = '0;
        if (!busy && (i_RS2 != '0)) begin
            o_REG_OUT2 = (byp_en && (i_RD == i_RS2)) ? i_REG_IN : mem[i_RS2];
        end
    end

    assign o_BUSY = busy;

endmodule

// File: tb/tb_register_file_core.sv
// Directed scoreboard bench: one bypassing and one non-bypassing instance
// share the same stimulus; expectations are queued and popped at negedge.
module tb_register_file_core;

    logic        CLK;
    logic        RST;
    logic        i_CLR;
    logic        i_WE;
    logic [4:0]  i_RD;
    logic [4:0]  i_RS1;
    logic [4:0]  i_RS2;
    logic [31:0] i_REG_IN;
    logic [31:0] b_out1, b_out2, n_out1, n_out2;
    logic        b_busy, n_busy;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic [31:0] b1;
        logic [31:0] b2;
        logic [31:0] n1;
        logic [31:0] n2;
        logic        bz;
    } exp_t;

    exp_t sb[$];

    register_file_core #(.BYPASS(1)) dut_b (
        .CLK(CLK), .RST(RST), .i_CLR(i_CLR), .i_WE(i_WE), .i_RD(i_RD),
        .i_RS1(i_RS1), .i_RS2(i_RS2), .i_REG_IN(i_REG_IN),
        .o_REG_OUT1(b_out1), .o_REG_OUT2(b_out2), .o_BUSY(b_busy)
    );

    register_file_core #(.BYPASS(0)) dut_n (
        .CLK(CLK), .RST(RST), .i_CLR(i_CLR), .i_WE(i_WE), .i_RD(i_RD),
        .i_RS1(i_RS1), .i_RS2(i_RS2), .i_REG_IN(i_REG_IN),
        .o_REG_OUT1(n_out1), .o_REG_OUT2(n_out2), .o_BUSY(n_busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] b1, input logic [31:0] b2,
                        input logic [31:0] n1, input logic [31:0] n2, input logic bz);
        exp_t e;
        e.tag = tag; e.b1 = b1; e.b2 = b2; e.n1 = n1; e.n2 = n2; e.bz = bz;
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t e;
        @(negedge CLK);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            cmp({e.tag, "_byp_out1"},   b_out1, e.b1);
            cmp({e.tag, "_byp_out2"},   b_out2, e.b2);
            cmp({e.tag, "_nobyp_out1"}, n_out1, e.n1);
            cmp({e.tag, "_nobyp_out2"}, n_out2, e.n2);
            cmp({e.tag, "_byp_busy"},   32'(b_busy), 32'(e.bz));
            cmp({e.tag, "_nobyp_busy"}, 32'(n_busy), 32'(e.bz));
        end
    endtask

    task automatic adv();
        @(posedge CLK);
        #1;
    endtask

    // Counts edges while busy is high, bounded; ends 1 time unit after an edge
    task automatic count_busy(output int n);
        n = 0;
        while (b_busy && n < 100) begin
            @(posedge CLK);
            n++;
            #1;
        end
    endtask

    int edges;

    initial begin
        RST = 1'b1; i_CLR = 1'b0; i_WE = 1'b0; i_RD = '0;
        i_RS1 = '0; i_RS2 = '0; i_REG_IN = '0;

        // Reset for two edges, then the clear walk
        adv();
        adv();
        i_RS1 = 5'd1; i_RS2 = 5'd31;
        push("reset", 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
        check_all();
        RST = 1'b0;
        count_busy(edges);
        cmp("reset_clear_edges", 32'(edges), 32'd31);
        for (int i = 1; i < 32; i++) begin
            i_RS1 = 5'(i);
            i_RS2 = 5'(32 - i);
            push("cleared", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
            check_all();
        end
        adv();

        // Write x5, bypass visible on one instance only
        i_WE = 1'b1; i_RD = 5'd5; i_REG_IN = 32'hDEADBEEF; i_RS1 = 5'd5; i_RS2 = 5'd0;
        push("wr5_same", 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 1'b0);
        check_all();
        adv();
        i_WE = 1'b0;
        push("wr5_next", 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0);
        check_all();
        adv();

        // x0 protection
        i_WE = 1'b1; i_RD = 5'd0; i_REG_IN = 32'h12345678; i_RS1 = 5'd0; i_RS2 = 5'd5;
        push("x0_same", 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b0);
        check_all();
        adv();
        i_WE = 1'b0;
        push("x0_next", 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b0);
        check_all();
        adv();

        // Bypass on x7
        i_WE = 1'b1; i_RD = 5'd7; i_REG_IN = 32'h11111111; i_RS1 = 5'd0; i_RS2 = 5'd0;
        adv();
        i_REG_IN = 32'hA5A5A5A5; i_RS1 = 5'd7; i_RS2 = 5'd7;
        push("byp_same", 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h11111111, 32'h11111111, 1'b0);
        check_all();
        adv();
        i_WE = 1'b0;
        push("byp_next", 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0);
        check_all();
        adv();

        // Clear colliding with a write to x3
        i_WE = 1'b1; i_RD = 5'd3; i_REG_IN = 32'hCAFEF00D;
        adv();
        i_WE = 1'b0; i_RS1 = 5'd3; i_RS2 = 5'd5;
        push("x3_set", 32'hCAFEF00D, 32'hDEADBEEF, 32'hCAFEF00D, 32'hDEADBEEF, 1'b0);
        check_all();
        adv();
        i_CLR = 1'b1; i_WE = 1'b1; i_RD = 5'd3; i_REG_IN = 32'h1; i_RS1 = 5'd5; i_RS2 = 5'd7;
        push("clr_req", 32'hDEADBEEF, 32'hA5A5A5A5, 32'hDEADBEEF, 32'hA5A5A5A5, 1'b0);
        check_all();
        adv();
        i_CLR = 1'b0; i_WE = 1'b0; i_RS1 = 5'd3; i_RS2 = 5'd3;
        push("clr_busy", 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
        check_all();
        count_busy(edges);
        cmp("clr_busy_cycles", 32'(edges), 32'd31);
        push("clr_x3", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        check_all();
        adv();

        // Reset in the middle of a clear, with writes attempted while busy
        i_WE = 1'b1; i_RD = 5'd9; i_REG_IN = 32'h00000099;
        adv();
        i_WE = 1'b0; i_RS1 = 5'd9; i_RS2 = 5'd0;
        push("x9_set", 32'h99, 32'h0, 32'h99, 32'h0, 1'b0);
        check_all();
        adv();
        i_CLR = 1'b1;
        adv();
        i_CLR = 1'b0;
        for (int k = 1; k < 10; k++) adv();
        RST = 1'b1;
        adv();
        RST = 1'b0;
        i_WE = 1'b1; i_RD = 5'd9; i_REG_IN = 32'h0BADBAD0; i_RS1 = 5'd9; i_RS2 = 5'd9;
        push("midrst_busy", 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
        check_all();
        count_busy(edges);
        i_WE = 1'b0;
        cmp("midrst_busy_edges", 32'(edges), 32'd31);
        push("midrst_x9", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        check_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
